serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor built around a single full-adder slice and a carry flop. It accepts two WIDTH-bit operands in parallel on a start strobe. It processes one bit per clock, LSB first, and presents the parallel sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal arithmetic option for control paths where latency is not critical.

---
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, LSB first.
// Operands load on start, WIDTH RUN cycles, then a one-cycle DONE with sum/cout/ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_bit, maj;

  assign s_bit = a_q[0] ^ b_q[0] ^ carry_q;
  assign maj   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // Handshake: start is accepted on any edge seen in IDLE (busy=0); the
  // operands are captured on that edge, and done is a single-cycle strobe
  // during which sum/cout/ovf are valid (they then hold until the next accept).
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = maj;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB slice, maj the carry out of it
          cout_d  = maj;
          ovf_d   = carry_q ^ maj;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sum       = res_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 instance checked every cycle against an
// arithmetic model, WIDTH=4 instance swept exhaustively in add and sub mode.
module tb_serial_adder;

  localparam int W8 = 8;
  localparam int W4 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic [1:0] dbg8;

  logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;
  logic [1:0] dbg4;

  serial_adder #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .dbg_state(dbg8)
  );

  serial_adder #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4), .dbg_state(dbg4)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {ovf, cout, 32-bit sum field}.
  function automatic logic [33:0] compute(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci,
                                          input logic sb);
    longint m, ua, ub, sa, sbv, full, sres;
    logic [33:0] r;
    m   = longint'(1) << w;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    if (sb) begin
      full = ua - ub + m;
      sres = sa - sbv;
    end else begin
      full = ua + ub + longint'(ci);
      sres = sa + sbv + longint'(ci);
    end
    r        = '0;
    r[31:0]  = 32'(full % m);
    r[32]    = (full >= m);
    r[33]    = (sres < -(m / 2)) || (sres >= m / 2);
    return r;
  endfunction

  // ---------------- scoreboard / model for WIDTH=8 ----------------
  int          cnt8  = 0;   // busy cycles still to come, 1 = done cycle
  logic [33:0] last8 = '0;  // result currently expected on the outputs
  logic [33:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt8  <= 0;
      last8 <= '0;
      exp_q.delete();
    end else if (cnt8 == 0) begin
      if (start8) begin
        exp_q.push_back(compute(W8, 32'(a8), 32'(b8), cin8, sub8));
        cnt8 <= W8 + 1;
      end
    end else begin
      if (cnt8 == 2 && exp_q.size() > 0) last8 <= exp_q.pop_front();
      cnt8 <= cnt8 - 1;
    end
  end

  always @(negedge clk) begin
    check("busy8", busy8, cnt8 > 0);
    check("done8", done8, cnt8 == 1);
    if (cnt8 <= 1) check("sum8", sum8, last8[7:0]);
    check("cout8", cout8, last8[32]);
    check("ovf8", ovf8, last8[33]);
  end

  // ---------------- driver tasks ----------------
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic sb, input logic [7:0] es, input logic ec,
                     input logic eo, input bit poke);
    int cyc;
    logic [33:0] r;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    cyc = 1;
    while (!done8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 3) begin
        start8 = 1'b1;
        a8     = 8'hAA;
      end else begin
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    check("lat8", cyc, W8 + 1);
    check("sum8_lit", sum8, es);
    check("cout8_lit", cout8, ec);
    check("ovf8_lit", ovf8, eo);
    r = compute(W8, 32'(a), 32'(b), ci, sb);
    check("model_lit", {r[33], r[32], r[7:0]}, {eo, ec, es});
    @(negedge clk);
    check("done8_drop", done8, 1'b0);
    check("sum8_hold", sum8, es);
  endtask

  task automatic rand8();
    @(negedge clk);
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    repeat (W8 + $urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic sb);
    int cyc;
    logic [33:0] r;
    @(negedge clk);
    a4 = a; b4 = b; cin4 = ci; sub4 = sb; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 1;
    while (!done4 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    r = compute(W4, 32'(a), 32'(b), ci, sb);
    check("lat4", cyc, W4 + 1);
    check("res4", {ovf4, cout4, sum4}, {r[33], r[32], r[3:0]});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int prev;
    int ndone;
    logic [8:0] v;

    repeat (2) @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_sum", sum8, 8'h00);
    check("rst_flags", {cout8, ovf8}, 2'b00);
    rst = 1'b0;

    op8(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    op8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    op8(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    op8(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);

    // start held high: done every W8+2 cycles
    @(negedge clk);
    a8 = 8'h21; b8 = 8'h13; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    prev  = -1;
    ndone = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (done8) begin
        if (prev >= 0) check("period8", i - prev, W8 + 2);
        prev = i;
        ndone++;
      end
    end
    start8 = 1'b0;
    check("ndone8", ndone, 3);
    repeat (12) @(negedge clk);

    // asynchronous reset after the 4th RUN edge
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy8, 1'b0);
    check("arst_done", done8, 1'b0);
    check("arst_sum", sum8, 8'h00);
    check("arst_flags", {cout8, ovf8}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("arst_nodone", ndone, 0);
    op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) rand8();

    // exhaustive WIDTH=4
    for (int x = 0; x < 512; x++) begin
      v = 9'(x);
      op4(v[3:0], v[7:4], v[8], 1'b0);
    end
    for (int x = 0; x < 512; x++) begin
      v = 9'(x);
      op4(v[3:0], v[7:4], v[8], 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
